// File: rtl/burst_ctrl_pkg.sv
// Shared types for the multi-channel burst controller: channel mode and per-channel FSM state.
package burst_ctrl_pkg;

  typedef enum logic [1:0] {ONE_SHOT, RETRIG, CONT, BURST_N} mode_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

endpackage

// File: rtl/burst_ch_fsm.sv
// One burst channel: IDLE/ACTIVE/GAP state, period and burst counters, config latched on trigger.
module burst_ch_fsm
  import burst_ctrl_pkg::*;
#(
  parameter int DUR_W = 8,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             abort,
  input  logic             period_tick,
  input  logic [1:0]       mode_i,
  input  logic [DUR_W-1:0] duration_i,
  input  logic [REP_W-1:0] repeat_i,
  output logic             active,
  output logic             done,
  output logic             busy
);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [DUR_W-1:0]   period_q, period_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [REP_W-1:0]   burst_q, burst_d;
  logic               done_q, done_d;

  logic               period_last;
  logic [DUR_W-1:0]   period_inc;
  logic [REP_W-1:0]   burst_inc;

  // Compare one bit wider so period_q + 1 cannot wrap before the compare.
  assign period_last = ({1'b0, period_q} + (DUR_W + 1)'(1)) >= {1'b0, dur_q};
  assign period_inc  = (period_q == '1) ? period_q : period_q + DUR_W'(1);
  assign burst_inc   = (burst_q == '1) ? burst_q : burst_q + REP_W'(1);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dur_d    = dur_q;
    period_d = period_q;
    rep_d    = rep_q;
    burst_d  = burst_q;
    done_d   = 1'b0;

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d  = ACTIVE;
            mode_d   = mode_t'(mode_i);
            dur_d    = (duration_i == '0) ? DUR_W'(1) : duration_i;
            rep_d    = (repeat_i == '0) ? REP_W'(1) : repeat_i;
            period_d = '0;
            burst_d  = REP_W'(1);
          end
        end
        ACTIVE: begin
          if (trigger && mode_q == RETRIG) begin
            period_d = '0;
          end else if (period_tick) begin
            if (period_last) begin
              period_d = '0;
              unique case (mode_q)
                CONT:    state_d = ACTIVE;
                BURST_N: begin
                  if (burst_q < rep_q) begin
                    state_d = GAP;
                  end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                  end
                end
                default: begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              endcase
            end else begin
              period_d = period_inc;
            end
          end
        end
        GAP: begin
          if (period_tick) begin
            if (period_last) begin
              state_d  = ACTIVE;
              period_d = '0;
              burst_d  = burst_inc;
            end else begin
              period_d = period_inc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: synchronous reset clears every register, including the latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= ONE_SHOT;
      dur_q    <= '0;
      period_q <= '0;
      rep_q    <= '0;
      burst_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dur_q    <= dur_d;
      period_q <= period_d;
      rep_q    <= rep_d;
      burst_q  <= burst_d;
      done_q   <= done_d;
    end
  end

  assign active = (state_q == ACTIVE);
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

endmodule

// File: rtl/burst_ctrl_fsm.sv
// NUM_CH independent burst channels gating PWM generators; busy is the OR of all channels.
// Optional sticky done interrupt (irq/irq_clr) when BURST_CTRL_DONE_IRQ_EN is defined.
module burst_ctrl_fsm
  import burst_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DUR_W  = 8,
  parameter int REP_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             trigger,
  input  logic [NUM_CH-1:0]             abort,
  input  logic [NUM_CH-1:0]             period_tick,
  input  logic [NUM_CH-1:0][1:0]        mode_i,
  input  logic [NUM_CH-1:0][DUR_W-1:0]  duration_i,
  input  logic [NUM_CH-1:0][REP_W-1:0]  repeat_i,
  output logic [NUM_CH-1:0]             active,
  output logic [NUM_CH-1:0]             done,
  output logic                          busy
`ifdef BURST_CTRL_DONE_IRQ_EN
  ,
  input  logic                          irq_clr,
  output logic                          irq
`endif
);

  logic [NUM_CH-1:0] ch_busy;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    burst_ch_fsm #(
      .DUR_W (DUR_W),
      .REP_W (REP_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .trigger     (trigger[ch]),
      .abort       (abort[ch]),
      .period_tick (period_tick[ch]),
      .mode_i      (mode_i[ch]),
      .duration_i  (duration_i[ch]),
      .repeat_i    (repeat_i[ch]),
      .active      (active[ch]),
      .done        (done[ch]),
      .busy        (ch_busy[ch])
    );
  end

  assign busy = |ch_busy;

`ifdef BURST_CTRL_DONE_IRQ_EN
  // Set has priority over clear so a done coinciding with irq_clr is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (|done) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_burst_ctrl_fsm.sv
// Directed bench for burst_ctrl_fsm; covers irq when BURST_CTRL_DONE_IRQ_EN is defined.
module tb_burst_ctrl_fsm;
  import burst_ctrl_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DUR_W  = 8;
  localparam int REP_W  = 8;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_CH-1:0]            trigger;
  logic [NUM_CH-1:0]            abort;
  logic [NUM_CH-1:0]            period_tick;
  logic [NUM_CH-1:0][1:0]       mode_i;
  logic [NUM_CH-1:0][DUR_W-1:0] duration_i;
  logic [NUM_CH-1:0][REP_W-1:0] repeat_i;
  logic [NUM_CH-1:0]            active;
  logic [NUM_CH-1:0]            done;
  logic                         busy;
`ifdef BURST_CTRL_DONE_IRQ_EN
  logic                         irq_clr;
  logic                         irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  burst_ctrl_fsm #(
    .NUM_CH (NUM_CH),
    .DUR_W  (DUR_W),
    .REP_W  (REP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .abort       (abort),
    .period_tick (period_tick),
    .mode_i      (mode_i),
    .duration_i  (duration_i),
    .repeat_i    (repeat_i),
    .active      (active),
    .done        (done),
    .busy        (busy)
`ifdef BURST_CTRL_DONE_IRQ_EN
    ,
    .irq_clr     (irq_clr),
    .irq         (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input mode_t m, input int d, input int r);
    mode_i[ch]     = m;
    duration_i[ch] = DUR_W'(d);
    repeat_i[ch]   = REP_W'(r);
  endtask

  task automatic pulse_trig(input logic [NUM_CH-1:0] m);
    trigger = m;
    step();
    trigger = '0;
  endtask

  task automatic tick(input logic [NUM_CH-1:0] m);
    period_tick = m;
    step();
    period_tick = '0;
  endtask

  initial begin
    logic [9:0] burst_pat;

    rst         = 1'b1;
    trigger     = '0;
    abort       = '0;
    period_tick = '0;
    mode_i      = '0;
    duration_i  = '0;
    repeat_i    = '0;
`ifdef BURST_CTRL_DONE_IRQ_EN
    irq_clr     = 1'b0;
`endif
    step();
    step();
    check("reset_active", active, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
`ifdef BURST_CTRL_DONE_IRQ_EN
    check("reset_irq", irq, 0);
`endif
    rst = 1'b0;
    step();

    // ONE_SHOT dur=3 on ch0, with a mid-burst config change and stray trigger ignored
    cfg(0, ONE_SHOT, 3, 0);
    pulse_trig(4'b0001);
    check("os_active_start", active, 4'b0001);
    check("os_busy", busy, 1);
    duration_i[0] = DUR_W'(1);
    tick(4'b0001);
    check("os_active_t1", active[0], 1);
    pulse_trig(4'b0001);
    tick(4'b0001);
    check("os_active_t2", active[0], 1);
    check("os_done_t2", done[0], 0);
    tick(4'b0001);
    check("os_active_t3", active[0], 0);
    check("os_done_t3", done, 4'b0001);
    step();
    check("os_done_pulse_end", done[0], 0);
    check("os_busy_end", busy, 0);

    // RETRIG dur=4 on ch0: retrigger after tick 2 -> 6 ticks total
    cfg(0, RETRIG, 4, 0);
    pulse_trig(4'b0001);
    tick(4'b0001);
    tick(4'b0001);
    pulse_trig(4'b0001);
    check("rt_active_retrig", active[0], 1);
    for (int k = 3; k <= 5; k++) begin
      tick(4'b0001);
      check($sformatf("rt_active_t%0d", k), active[0], 1);
      check($sformatf("rt_done_t%0d", k), done[0], 0);
    end
    tick(4'b0001);
    check("rt_active_t6", active[0], 0);
    check("rt_done_t6", done[0], 1);
    step();
    check("rt_single_done", done[0], 0);

    // BURST_N dur=2 rep=3 on ch2: expected active after ticks 1..10
    cfg(2, BURST_N, 2, 3);
    burst_pat = 10'b1_1001_1001_1 ;
    // bit (k-1) from MSB side: ticks 1..10 -> 1,0,0,1,1,0,0,1,1,0
    burst_pat = 10'b1001100110;
    pulse_trig(4'b0100);
    check("bn_active_start", active[2], 1);
    for (int k = 1; k <= 10; k++) begin
      tick(4'b0100);
      check($sformatf("bn_active_t%0d", k), active[2], burst_pat[10-k]);
      check($sformatf("bn_done_t%0d", k), done[2], (k == 10) ? 1 : 0);
      check($sformatf("bn_busy_t%0d", k), busy, (k == 10) ? 0 : 1);
    end
    step();
    check("bn_done_end", done[2], 0);

    // CONT on ch1 + ONE_SHOT dur=20 on ch0; abort ch1 with a tick in the same cycle
    cfg(0, ONE_SHOT, 20, 0);
    cfg(1, CONT, 3, 0);
    pulse_trig(4'b0011);
    for (int k = 0; k < 10; k++) tick(4'b0011);
    check("ct_active_10", active, 4'b0011);
    check("ct_done_10", done, 0);
    abort       = 4'b0010;
    period_tick = 4'b0011;
    step();
    abort       = '0;
    period_tick = '0;
    check("ct_abort_active", active, 4'b0001);
    check("ct_abort_done", done, 4'b0010);
    step();
    check("ct_done_clear", done, 0);
    abort = 4'b0010;
    step();
    abort = '0;
    check("abort_idle_nodone", done, 0);
    abort = 4'b0001;
    step();
    abort = '0;
    check("ct_abort_ch0_done", done, 4'b0001);
    check("ct_abort_ch0_active", active, 0);
    step();

    // dur=0 rep=0 BURST_N on ch3 -> single one-period burst
    cfg(3, BURST_N, 0, 0);
    pulse_trig(4'b1000);
    check("z_active", active[3], 1);
    tick(4'b1000);
    check("z_active_end", active[3], 0);
    check("z_done", done[3], 1);
    step();

    // rst during ACTIVE -> idle, no done
    cfg(0, ONE_SHOT, 5, 0);
    pulse_trig(4'b0001);
    check("rst_pre_active", active[0], 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    step();
    check("rst_no_done_after", done, 0);

`ifdef BURST_CTRL_DONE_IRQ_EN
    cfg(2, ONE_SHOT, 1, 0);
    pulse_trig(4'b0100);
    tick(4'b0100);
    check("irq_done2", done[2], 1);
    step();
    check("irq_set", irq, 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("irq_cleared", irq, 0);
    cfg(0, ONE_SHOT, 1, 0);
    pulse_trig(4'b0001);
    tick(4'b0001);
    check("irq_done0", done[0], 1);
    irq_clr = 1'b1;
    step();
    check("irq_set_wins", irq, 1);
    step();
    irq_clr = 1'b0;
    check("irq_clr_alone", irq, 0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
